// File: rtl/vec_store_serializer.sv
// ---------------------------------------------------------------------------
// vec_store_serializer
//
// Serializes a scalar or an I-element packed vector into consecutive
// single-word memory writes, one word per clock, at ascending addresses.
// Address arithmetic wraps modulo 2^A.
//
// Optional feature: define VEC_STORE_MASK_EN to add the elem_mask input.
// A slot whose mask bit is 0 keeps its address and its cycle but does not
// assert mem_wren. A scalar store uses mask bit 0.
//
// Ports
//   clk           system clock, all state changes on the rising edge
//   rst           synchronous active-low reset
//   start         level request, sampled in IDLE
//   op_type       0 = scalar (one word), 1 = vector (I words)
//   base_address  address of element 0 or of the scalar
//   vector_data   packed vector, element k = [k*L +: L]
//   scalar_data   scalar word
//   elem_mask     per-element write mask (VEC_STORE_MASK_EN only)
//   mem_address   registered memory address
//   mem_wdata     registered memory write data
//   mem_wren      registered memory write enable
//   busy          high while in WRITE
//   finished      high while in DONE
// ---------------------------------------------------------------------------
module vec_store_serializer #(
    parameter int I = 20,
    parameter int L = 8,
    parameter int A = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_type,
    input  logic [A-1:0]     base_address,
    input  logic [I*L-1:0]   vector_data,
    input  logic [L-1:0]     scalar_data,
`ifdef VEC_STORE_MASK_EN
    input  logic [I-1:0]     elem_mask,
`endif
    output logic [A-1:0]     mem_address,
    output logic [L-1:0]     mem_wdata,
    output logic             mem_wren,
    output logic             busy,
    output logic             finished
);

    localparam int CW = $clog2(I + 1);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DONE
    } state_t;

    state_t         state;
    logic [I*L-1:0] data_q;     // captured vector, shifted down one element per write
    logic [I*L-1:0] data_next;
    logic [CW-1:0]  count_q;    // words in this store (1 or I)
    logic [CW-1:0]  idx_q;      // index of the word currently driven
    logic           first_en;   // write enable for slot 0
    logic           next_en;    // write enable for the next slot

    assign data_next = data_q >> L;

`ifdef VEC_STORE_MASK_EN
    logic [I-1:0] mask_q;
    logic [I-1:0] mask_next;

    assign mask_next = mask_q >> 1;
    assign first_en  = elem_mask[0];
    assign next_en   = mask_next[0];
`else
    assign first_en  = 1'b1;
    assign next_en   = 1'b1;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: the reset is synchronous and clears the captured data as
            // well as the control state, so nothing from an aborted store
            // can leak into the next one.
            state       <= IDLE;
            data_q      <= '0;
            count_q     <= '0;
            idx_q       <= '0;
            mem_address <= '0;
            mem_wdata   <= '0;
            mem_wren    <= 1'b0;
            busy        <= 1'b0;
            finished    <= 1'b0;
`ifdef VEC_STORE_MASK_EN
            mask_q      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // Capture edge: latch inputs and drive word 0 at once.
                        state       <= WRITE;
                        data_q      <= vector_data;
                        count_q     <= op_type ? CW'(I) : CW'(1);
                        idx_q       <= '0;
                        mem_address <= base_address;
                        mem_wdata   <= op_type ? vector_data[L-1:0] : scalar_data;
                        mem_wren    <= first_en;
                        busy        <= 1'b1;
`ifdef VEC_STORE_MASK_EN
                        mask_q      <= elem_mask;
`endif
                    end
                end

                WRITE: begin
                    if (idx_q == count_q - CW'(1)) begin
                        state    <= DONE;
                        mem_wren <= 1'b0;
                        busy     <= 1'b0;
                        finished <= 1'b1;
                    end else begin
                        idx_q       <= idx_q + CW'(1);
                        mem_address <= mem_address + A'(1);
                        mem_wdata   <= data_next[L-1:0];
                        data_q      <= data_next;
                        mem_wren    <= next_en;
`ifdef VEC_STORE_MASK_EN
                        mask_q      <= mask_next;
`endif
                    end
                end

                DONE: begin
                    // Stay here while start is held so a level request
                    // cannot retrigger; a new store needs start to drop.
                    if (!start) begin
                        state    <= IDLE;
                        finished <= 1'b0;
                    end
                end

                default: begin
                    state    <= IDLE;
                    mem_wren <= 1'b0;
                    busy     <= 1'b0;
                    finished <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vec_store_serializer.sv
// ---------------------------------------------------------------------------
// tb_vec_store_serializer
//
// Directed self-checking bench for vec_store_serializer (I=20, L=8, A=16).
// Outputs are sampled 1 time unit after the rising edge; memory writes are
// logged on the falling edge, where a memory would sample them.
// Define VEC_STORE_MASK_EN to also exercise the element mask.
// ---------------------------------------------------------------------------
module tb_vec_store_serializer;

    localparam int I = 20;
    localparam int L = 8;
    localparam int A = 16;

    logic           clk;
    logic           rst;
    logic           start;
    logic           op_type;
    logic [A-1:0]   base_address;
    logic [I*L-1:0] vector_data;
    logic [L-1:0]   scalar_data;
`ifdef VEC_STORE_MASK_EN
    logic [I-1:0]   elem_mask;
`endif
    logic [A-1:0]   mem_address;
    logic [L-1:0]   mem_wdata;
    logic           mem_wren;
    logic           busy;
    logic           finished;

    int checks = 0;
    int errors = 0;

    // Write log filled on the falling edge.
    int             pulses;
    logic [A-1:0]   log_addr[$];
    logic [L-1:0]   log_data[$];

    // Per-cycle observations; index c = after the c-th edge from capture.
    logic [A-1:0]   obs_addr [0:31];
    logic [L-1:0]   obs_data [0:31];
    logic           obs_wren [0:31];
    logic           obs_busy [0:31];
    logic           obs_fin  [0:31];

    vec_store_serializer #(.I(I), .L(L), .A(A)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .op_type      (op_type),
        .base_address (base_address),
        .vector_data  (vector_data),
        .scalar_data  (scalar_data),
`ifdef VEC_STORE_MASK_EN
        .elem_mask    (elem_mask),
`endif
        .mem_address  (mem_address),
        .mem_wdata    (mem_wdata),
        .mem_wren     (mem_wren),
        .busy         (busy),
        .finished     (finished)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_wren === 1'b1) begin
            pulses++;
            log_addr.push_back(mem_address);
            log_data.push_back(mem_wdata);
        end
    end

    task automatic clear_log();
        pulses = 0;
        log_addr.delete();
        log_data.delete();
    endtask

    // Vector whose element k holds k+1.
    function automatic logic [I*L-1:0] ramp_vec();
        logic [I*L-1:0] v;
        v = '0;
        for (int k = 0; k < I; k++) v[k*L +: L] = L'(k + 1);
        return v;
    endfunction

    // Present a store request and record ncyc post-edge samples.
    task automatic run_store(input logic op, input logic [A-1:0] base,
                             input logic [I*L-1:0] vec, input logic [L-1:0] scal,
                             input int ncyc);
        op_type      = op;
        base_address = base;
        vector_data  = vec;
        scalar_data  = scal;
        start        = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            obs_addr[c] = mem_address;
            obs_data[c] = mem_wdata;
            obs_wren[c] = mem_wren;
            obs_busy[c] = busy;
            obs_fin[c]  = finished;
        end
    endtask

    task automatic idle_gap();
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        start = 1'b1;   // reset must win over start
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if ({mem_address, mem_wdata, mem_wren, busy, finished} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got addr=%h data=%h wren=%b busy=%b fin=%b, expected all 0",
                     mem_address, mem_wdata, mem_wren, busy, finished);
        end
        start = 1'b0;
        rst   = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || mem_wren !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: got busy=%b wren=%b, expected 0 0", busy, mem_wren);
        end
    endtask

    task automatic test_vector();
        logic [A-1:0] ea;
        clear_log();
        run_store(1'b1, 16'h0100, ramp_vec(), 8'h00, 22);
        for (int k = 0; k < I; k++) begin
            ea = 16'h0100 + A'(k);
            checks++;
            if (obs_addr[k] !== ea || obs_data[k] !== L'(k + 1) || obs_wren[k] !== 1'b1
                || obs_busy[k] !== 1'b1 || obs_fin[k] !== 1'b0) begin
                errors++;
                $display("FAIL vec_slot%0d: got addr=%h data=%h wren=%b busy=%b fin=%b, expected %h %h 1 1 0",
                         k, obs_addr[k], obs_data[k], obs_wren[k], obs_busy[k], obs_fin[k], ea, L'(k + 1));
            end
        end
        checks++;
        if (obs_fin[20] !== 1'b1 || obs_wren[20] !== 1'b0 || obs_busy[20] !== 1'b0) begin
            errors++;
            $display("FAIL vec_done_edge20: got fin=%b wren=%b busy=%b, expected 1 0 0",
                     obs_fin[20], obs_wren[20], obs_busy[20]);
        end
        checks++;
        if (obs_fin[21] !== 1'b1 || obs_wren[21] !== 1'b0) begin
            errors++;
            $display("FAIL vec_done_hold: got fin=%b wren=%b, expected 1 0", obs_fin[21], obs_wren[21]);
        end
        start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (finished !== 1'b0) begin
            errors++;
            $display("FAIL vec_done_release: got fin=%b, expected 0", finished);
        end
        checks++;
        if (pulses !== 20) begin
            errors++;
            $display("FAIL vec_pulse_count: got %0d, expected 20", pulses);
        end
        idle_gap();
    endtask

    task automatic test_scalar();
        clear_log();
        run_store(1'b0, 16'h0042, {I{8'h3C}}, 8'hA5, 3);
        checks++;
        if (obs_addr[0] !== 16'h0042 || obs_data[0] !== 8'hA5 || obs_wren[0] !== 1'b1 || obs_busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL scalar_write: got addr=%h data=%h wren=%b busy=%b, expected 0042 a5 1 1",
                     obs_addr[0], obs_data[0], obs_wren[0], obs_busy[0]);
        end
        checks++;
        if (obs_fin[1] !== 1'b1 || obs_wren[1] !== 1'b0) begin
            errors++;
            $display("FAIL scalar_done: got fin=%b wren=%b, expected 1 0", obs_fin[1], obs_wren[1]);
        end
        checks++;
        if (obs_fin[2] !== 1'b1) begin
            errors++;
            $display("FAIL scalar_hold: got fin=%b, expected 1", obs_fin[2]);
        end
        start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (finished !== 1'b0) begin
            errors++;
            $display("FAIL scalar_release: got fin=%b, expected 0", finished);
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL scalar_pulse_count: got %0d, expected 1", pulses);
        end
        idle_gap();
    endtask

    task automatic test_wrap();
        logic [A-1:0] ea;
        clear_log();
        run_store(1'b1, 16'hFFFE, ramp_vec(), 8'h00, 21);
        for (int k = 0; k < I; k++) begin
            ea = 16'hFFFE + A'(k);
            checks++;
            if (obs_addr[k] !== ea || obs_wren[k] !== 1'b1) begin
                errors++;
                $display("FAIL wrap_slot%0d: got addr=%h wren=%b, expected %h 1", k, obs_addr[k], obs_wren[k], ea);
            end
        end
        checks++;
        if (pulses !== 20 || log_addr[19] !== 16'h0011 || log_addr[2] !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_log: got pulses=%0d, expected 20 ending at 0011", pulses);
        end
        idle_gap();
    endtask

    task automatic test_reset_mid_write();
        clear_log();
        run_store(1'b1, 16'h0200, ramp_vec(), 8'h00, 4);
        rst = 1'b0;   // start stays high
        @(posedge clk); #1;
        checks++;
        if ({mem_address, mem_wdata, mem_wren, busy, finished} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got addr=%h data=%h wren=%b busy=%b fin=%b, expected all 0",
                     mem_address, mem_wdata, mem_wren, busy, finished);
        end
        @(posedge clk); #1;
        checks++;
        if (pulses !== 4) begin
            errors++;
            $display("FAIL midreset_pulse_count: got %0d, expected 4", pulses);
        end
        start = 1'b0;
        rst   = 1'b1;
        @(posedge clk); #1;
        clear_log();
        run_store(1'b1, 16'h0300, ramp_vec(), 8'h00, 21);
        checks++;
        if (obs_addr[0] !== 16'h0300 || obs_data[0] !== 8'h01 || obs_wren[0] !== 1'b1) begin
            errors++;
            $display("FAIL midreset_restart_first: got addr=%h data=%h wren=%b, expected 0300 01 1",
                     obs_addr[0], obs_data[0], obs_wren[0]);
        end
        checks++;
        if (obs_fin[20] !== 1'b1 || pulses !== 20 || log_addr[19] !== 16'h0313 || log_data[19] !== 8'h14) begin
            errors++;
            $display("FAIL midreset_restart_done: got fin=%b pulses=%0d, expected 1 20", obs_fin[20], pulses);
        end
        idle_gap();
    endtask

    task automatic test_input_isolation();
        logic ok;
        clear_log();
        run_store(1'b1, 16'h0400, ramp_vec(), 8'h00, 6);
        // Disturb every data input and pulse start while the store runs.
        vector_data  = {I{8'hEE}};
        scalar_data  = 8'hEE;
        base_address = 16'h0000;
        op_type      = 1'b0;
        for (int c = 6; c <= 21; c++) begin
            start = (c != 6);
            @(posedge clk); #1;
            obs_fin[c]  = finished;
            obs_wren[c] = mem_wren;
        end
        ok = (pulses == 20);
        for (int k = 0; k < I && ok; k++)
            ok = (log_addr[k] === 16'h0400 + A'(k)) && (log_data[k] === L'(k + 1));
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL isolate_log: got pulses=%0d, expected 20 writes of k+1 at 0400+k", pulses);
        end
        checks++;
        if (obs_fin[19] !== 1'b0 || obs_fin[20] !== 1'b1 || obs_fin[21] !== 1'b1 || obs_wren[21] !== 1'b0) begin
            errors++;
            $display("FAIL isolate_done: got fin19=%b fin20=%b fin21=%b wren21=%b, expected 0 1 1 0",
                     obs_fin[19], obs_fin[20], obs_fin[21], obs_wren[21]);
        end
        idle_gap();
    endtask

`ifdef VEC_STORE_MASK_EN
    task automatic test_mask();
        clear_log();
        elem_mask = 20'h00005;
        run_store(1'b1, 16'h0500, ramp_vec(), 8'h00, 21);
        for (int k = 0; k < I; k++) begin
            checks++;
            if (obs_wren[k] !== (k == 0 || k == 2) || obs_addr[k] !== 16'h0500 + A'(k)) begin
                errors++;
                $display("FAIL mask_slot%0d: got wren=%b addr=%h, expected %b %h",
                         k, obs_wren[k], obs_addr[k], (k == 0 || k == 2), 16'h0500 + A'(k));
            end
        end
        checks++;
        if (obs_fin[20] !== 1'b1 || pulses !== 2 || log_data[0] !== 8'h01 || log_data[1] !== 8'h03) begin
            errors++;
            $display("FAIL mask_done: got fin=%b pulses=%0d, expected 1 2", obs_fin[20], pulses);
        end
        idle_gap();
        clear_log();
        elem_mask = 20'h00000;
        run_store(1'b0, 16'h0600, '0, 8'h5A, 2);
        checks++;
        if (obs_wren[0] !== 1'b0 || obs_fin[1] !== 1'b1 || pulses !== 0) begin
            errors++;
            $display("FAIL mask_scalar: got wren=%b fin=%b pulses=%0d, expected 0 1 0",
                     obs_wren[0], obs_fin[1], pulses);
        end
        elem_mask = '1;
        idle_gap();
    endtask
`endif

    initial begin
        rst          = 1'b0;
        start        = 1'b0;
        op_type      = 1'b0;
        base_address = '0;
        vector_data  = '0;
        scalar_data  = '0;
`ifdef VEC_STORE_MASK_EN
        elem_mask    = '1;
`endif
        clear_log();

        test_reset();
        test_vector();
        test_scalar();
        test_wrap();
        test_reset_mid_write();
        test_input_isolation();
`ifdef VEC_STORE_MASK_EN
        test_mask();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vec_store_serializer.md
VEC_STORE_SERIALIZER -- requirements
Module: vec_store_serializer

Interface
REQ-001 Parameter I, default 20, number of elements per vector.
REQ-002 Parameter L, default 8, element width in bits; equals memory word width.
REQ-003 Parameter A, default 16, memory address width.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  level request; a store begins when sampled high in IDLE.
REQ-007 op_type  input  1  store kind: 0 = scalar (one word), 1 = vector (I words).
REQ-008 base_address  input  A  address of element 0 or of the scalar.
REQ-009 vector_data  input  I x L  packed vector; element k is bits [k*L +: L].
REQ-010 scalar_data  input  L  scalar word to store.
REQ-011 mem_address  output  A  registered memory address.
REQ-012 mem_wdata  output  L  registered memory write data.
REQ-013 mem_wren  output  1  registered memory write enable.
REQ-014 busy  output  1  high in WRITE state.
REQ-015 finished  output  1  high in DONE state.

Function
REQ-016 FSM states IDLE, WRITE, DONE; IDLE is the reset state.
REQ-017 IDLE -> WRITE on rising edge with start=1; same edge captures op_type, base_address, vector_data, scalar_data into internal registers, loads count = (op_type ? I : 1), and drives element 0.
REQ-018 Inputs other than rst and start are ignored outside the capture edge; changes during WRITE do not affect the stored data.
REQ-019 In WRITE, after the k-th edge following capture (k = 0..count-1): mem_address = base + k, mem_wdata = element k (scalar_data for scalar), mem_wren = 1.
REQ-020 Element order ascending: element 0 at base, element I-1 at base+I-1.
REQ-021 Address arithmetic is modulo 2^A; base 0xFFFF with I=20 writes 0xFFFF, then 0x0000..0x0012.
REQ-022 WRITE -> DONE on the edge after the last word is driven; mem_wren = 0 in DONE.
REQ-023 Vector store: finished rises exactly I edges after the capture edge; scalar store: 1 edge.
REQ-024 DONE holds finished=1 while start=1; DONE -> IDLE on the first edge with start=0.
REQ-025 start=1 during WRITE or DONE never starts a new store; back-to-back stores require start to drop for at least one cycle.
REQ-026 Outputs change only on the rising edge and stay stable over the falling edge, where the memory samples.
REQ-027 mem_wren never asserts in IDLE or DONE; exactly count write pulses per store.

Reset
REQ-028 rst=0 at a rising edge forces IDLE: mem_address=0, mem_wdata=0, mem_wren=0, busy=0, finished=0, count and captured registers cleared.
REQ-029 Reset mid-WRITE aborts the store; no further write pulses after the reset edge.
REQ-030 rst=0 overrides start on the same edge; the first store after reset needs start sampled high with rst=1.

Configuration
REQ-031 Macro VEC_STORE_MASK_EN adds input elem_mask (width I), captured with the data on the start edge.
REQ-032 With VEC_STORE_MASK_EN: element k with mask bit 0 drives mem_wren=0 in its slot; address still advances and latency is unchanged; scalar store uses bit 0.
REQ-033 Without VEC_STORE_MASK_EN: no elem_mask port; every slot writes.

Verification
REQ-034 Vector store, base 0x0100, element k = k+1, start held high -> writes 0x01..0x14 to 0x0100..0x0113 on 20 consecutive cycles, finished 20 edges after capture.
REQ-035 Scalar store, base 0x0042, data 0xA5 -> one write of 0xA5 to 0x0042; finished on the next edge; finished drops one edge after start goes low.
REQ-036 Vector store at base 0xFFFE -> addresses 0xFFFE, 0xFFFF, 0x0000..0x0011; no write outside them.
REQ-037 rst=0 on the 5th write cycle -> mem_wren=0 and all outputs zero from that edge; exactly 4 prior pulses recorded; new start then stores normally.
REQ-038 Change vector_data and pulse start mid-WRITE -> memory holds originally captured data, no extra pulses; with VEC_STORE_MASK_EN and mask 0x00005 only elements 0 and 2 are written, finished still at edge 20.
